// File: rtl/branch_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
//   Shared definitions for the ID-stage branch resolve controller:
//   - Branch_Op encodings (must match the comparator's decode)
//   - FSM state encodings
//   - BRANCH_OP_VALID helper and a 32-bit saturating adder used by the
//     optional statistics counters (BRANCH_STATS_EN).
// ---------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  // Comparator op codes; 3'b110 and 3'b111 are unused/invalid.
  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BGEZ = 3'b001;
  localparam logic [2:0] OP_BGTZ = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;

  // FSM states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_RESOLVE  = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Default hazard-wait limit; the wait counter is 4 bits wide.
  localparam logic [3:0] MAX_WAIT_DEFAULT = 4'd15;

  // Every encoding up to BNE is a real branch.
  function automatic logic BRANCH_OP_VALID(input logic [2:0] op);
    return (op <= OP_BNE);
  endfunction

  // a + b, clamped at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/branch_stats.sv
// ---------------------------------------------------------------------------
// branch_stats
//   Saturating statistics counters for branch_resolve_ctrl. Present only when
//   the BRANCH_STATS_EN macro is defined (the whole file is guarded so the
//   default build carries no extra module).
//
//   Ports:
//     Clock, Reset_n   clock / synchronous active-low reset
//     accept           branch accepted in IDLE (restarts per-branch wait tally)
//     in_wait          controller spends this cycle in WAIT (not killed)
//     resolve_fire     controller resolves a branch this cycle (not killed)
//     taken_fire       resolve_fire with the comparator reporting taken
//     Branch_Count     branches resolved
//     Taken_Count      redirects issued
//     Stall_Cycles     WAIT cycles of branches that went on to resolve
// ---------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
module branch_stats
  import branch_resolve_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        accept,
  input  logic        in_wait,
  input  logic        resolve_fire,
  input  logic        taken_fire,
  output logic [31:0] Branch_Count,
  output logic [31:0] Taken_Count,
  output logic [31:0] Stall_Cycles
);

  // WAIT cycles of the branch in flight. Committed to Stall_Cycles only when
  // that branch resolves, so killed and timed-out branches never count.
  // At most MAX_WAIT+1 = 16 cycles, hence 5 bits.
  logic [4:0] pending_q;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      pending_q    <= '0;
      Branch_Count <= '0;
      Taken_Count  <= '0;
      Stall_Cycles <= '0;
    end else begin
      if (accept) begin
        pending_q <= '0;
      end else if (in_wait) begin
        pending_q <= 5'(pending_q + 5'd1);
      end
      if (resolve_fire) begin
        Branch_Count <= sat_add32(Branch_Count, 32'd1);
        Stall_Cycles <= sat_add32(Stall_Cycles, {27'd0, pending_q});
      end
      if (taken_fire) begin
        Taken_Count <= sat_add32(Taken_Count, 32'd1);
      end
    end
  end

endmodule
`endif

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   Sequencing controller for the ID-stage branch comparator. Accepts one
//   conditional branch from decode, stalls while operand hazards clear,
//   gives the comparator one resolve cycle and issues a one-cycle PC
//   redirect plus IF/ID flush when the branch is taken.
//
//   Optional feature macro: BRANCH_STATS_EN (adds Branch_Count, Taken_Count,
//   Stall_Cycles via the branch_stats sub-module).
//
//   Ports:
//     Clock, Reset_n     clock / synchronous active-low reset
//     Branch_Valid       decode presents a conditional branch
//     Branch_Op[2:0]     branch type (see package encodings)
//     Branch_Target[31:0] target address, sampled with Branch_Valid
//     Hazard_A/B         operand not yet forwardable
//     Kill               squash from a younger stage; aborts any branch
//     Cmp_Result         comparator result (combinational from Cmp_Control)
//     Cmp_Control[2:0]   comparator op code (held op_q)
//     Stall              hold PC and IF/ID (combinational)
//     Flush, PC_Src      one-cycle redirect to Target_Out
//     Target_Out[31:0]   registered branch target
//     Timeout            one-cycle pulse when the hazard wait expires
//     Dbg_State[1:0]     current FSM state
//
//   Handshake: decode holds Branch_Valid/Branch_Op/Branch_Target stable while
//   Stall is high; a branch is taken over only in IDLE with a valid op and
//   Kill low. Branch_Valid in any other state is ignored.
// ---------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter logic [3:0] MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Branch_Valid,
  input  logic [2:0]  Branch_Op,
  input  logic [31:0] Branch_Target,
  input  logic        Hazard_A,
  input  logic        Hazard_B,
  input  logic        Kill,
  input  logic        Cmp_Result,
  output logic [2:0]  Cmp_Control,
  output logic        Stall,
  output logic        Flush,
  output logic        PC_Src,
  output logic [31:0] Target_Out,
  output logic        Timeout,
`ifdef BRANCH_STATS_EN
  output logic [31:0] Branch_Count,
  output logic [31:0] Taken_Count,
  output logic [31:0] Stall_Cycles,
`endif
  output logic [1:0]  Dbg_State
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] tgt_q, tgt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        accept;

  // Next-state logic. Kill overrides every other transition.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    accept     = 1'b0;
    if (Kill) begin
      state_d    = ST_IDLE;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wait_cnt_d = '0;
          // Invalid ops are dropped without touching op_q/tgt_q.
          if (Branch_Valid && BRANCH_OP_VALID(Branch_Op)) begin
            accept  = 1'b1;
            op_d    = Branch_Op;
            tgt_d   = Branch_Target;
            state_d = (Hazard_A || Hazard_B) ? ST_WAIT : ST_RESOLVE;
          end
        end
        ST_WAIT: begin
          if (!Hazard_A && !Hazard_B) begin
            state_d = ST_RESOLVE;
          end else if (wait_cnt_q == MAX_WAIT) begin
            // Entered WAIT MAX_WAIT+1 cycles ago and still blocked.
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = 4'(wait_cnt_q + 4'd1);
          end
        end
        ST_RESOLVE: begin
          state_d = Cmp_Result ? ST_REDIRECT : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_BEQ;
      tgt_q      <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tgt_q      <= tgt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Stall covers the accept cycle too so decode holds the branch while it
  // is handed over; REDIRECT releases the front end for the new fetch.
  always_comb begin
    Stall = 1'b0;
    case (state_q)
      ST_IDLE:    Stall = accept;
      ST_WAIT:    Stall = 1'b1;
      ST_RESOLVE: Stall = 1'b1;
      default:    Stall = 1'b0;
    endcase
  end

  // Redirect comes straight from the REDIRECT state register; a Kill in
  // that same cycle masks it so a squashed branch never steers the PC.
  assign PC_Src      = (state_q == ST_REDIRECT) && !Kill;
  assign Flush       = (state_q == ST_REDIRECT) && !Kill;
  assign Cmp_Control = op_q;
  assign Target_Out  = tgt_q;
  assign Timeout     = timeout_q;
  assign Dbg_State   = state_q;

`ifdef BRANCH_STATS_EN
  logic resolve_fire;
  logic taken_fire;
  logic in_wait;

  assign resolve_fire = (state_q == ST_RESOLVE) && !Kill;
  assign taken_fire   = resolve_fire && Cmp_Result;
  assign in_wait      = (state_q == ST_WAIT) && !Kill;

  branch_stats u_stats (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .accept       (accept),
    .in_wait      (in_wait),
    .resolve_fire (resolve_fire),
    .taken_fire   (taken_fire),
    .Branch_Count (Branch_Count),
    .Taken_Count  (Taken_Count),
    .Stall_Cycles (Stall_Cycles)
  );
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Directed bench for branch_resolve_ctrl. Inputs change 1 time unit after
//   the rising edge; outputs are checked 2 units after it.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Branch_Valid;
  logic [2:0]  Branch_Op;
  logic [31:0] Branch_Target;
  logic        Hazard_A;
  logic        Hazard_B;
  logic        Kill;
  logic        Cmp_Result;
  logic [2:0]  Cmp_Control;
  logic        Stall;
  logic        Flush;
  logic        PC_Src;
  logic [31:0] Target_Out;
  logic        Timeout;
  logic [1:0]  Dbg_State;
`ifdef BRANCH_STATS_EN
  logic [31:0] Branch_Count;
  logic [31:0] Taken_Count;
  logic [31:0] Stall_Cycles;
`endif

  int errors = 0;
  int checks = 0;
  int timeout_pulses = 0;
  int redirect_pulses = 0;
  int exp_redirects = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tgt;

  branch_resolve_ctrl dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .Branch_Valid  (Branch_Valid),
    .Branch_Op     (Branch_Op),
    .Branch_Target (Branch_Target),
    .Hazard_A      (Hazard_A),
    .Hazard_B      (Hazard_B),
    .Kill          (Kill),
    .Cmp_Result    (Cmp_Result),
    .Cmp_Control   (Cmp_Control),
    .Stall         (Stall),
    .Flush         (Flush),
    .PC_Src        (PC_Src),
    .Target_Out    (Target_Out),
    .Timeout       (Timeout),
`ifdef BRANCH_STATS_EN
    .Branch_Count  (Branch_Count),
    .Taken_Count   (Taken_Count),
    .Stall_Cycles  (Stall_Cycles),
`endif
    .Dbg_State     (Dbg_State)
  );

  // Clock / pulse monitors
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Timeout === 1'b1) timeout_pulses++;
    if (PC_Src === 1'b1) redirect_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Branch_Valid  = 1'b0;
    Branch_Op     = OP_BEQ;
    Branch_Target = '0;
    Hazard_A      = 1'b0;
    Hazard_B      = 1'b0;
    Kill          = 1'b0;
    Cmp_Result    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: each taken branch pushes its target; a redirect pops it.
  task automatic chk_redirect_target(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%0h expected=no_redirect", tag, Target_Out);
    end else begin
      e = exp_q.pop_front();
      chk(tag, Target_Out, e);
    end
  endtask

  // Full branch: hz hazard cycles on operand A, then resolve with tk.
  task automatic run_branch(input logic [2:0] op, input logic [31:0] t,
                            input int hz, input logic tk);
    Branch_Valid  = 1'b1;
    Branch_Op     = op;
    Branch_Target = t;
    Hazard_A      = (hz > 0);
    if (tk) begin
      exp_q.push_back(t);
      exp_redirects++;
    end
    #1 chk("run_accept_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    Branch_Valid = 1'b0;
    for (int i = 1; i < hz; i++) begin
      #1 chk("run_wait", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
      next_cycle();
    end
    Hazard_A = 1'b0;
    if (hz > 0) begin
      #1 chk("run_wait_last", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
      next_cycle();
    end
    Cmp_Result = tk;
    #1 chk("run_resolve", {30'd0, Dbg_State}, {30'd0, ST_RESOLVE});
    chk("run_cmp_control", {29'd0, Cmp_Control}, {29'd0, op});
    next_cycle();
    Cmp_Result = 1'b0;
    if (tk) begin
      #1 chk("run_pc_src", {31'd0, PC_Src}, 32'd1);
      chk_redirect_target("run_target");
      next_cycle();
    end
  endtask

  // Directed sequence
  initial begin
    idle_inputs();
    Reset_n = 1'b0;
    repeat (2) next_cycle();
    #1;
    chk("rst_state",   {30'd0, Dbg_State},   {30'd0, ST_IDLE});
    chk("rst_cmp",     {29'd0, Cmp_Control}, 32'd0);
    chk("rst_stall",   {31'd0, Stall},       32'd0);
    chk("rst_flush",   {31'd0, Flush},       32'd0);
    chk("rst_pc_src",  {31'd0, PC_Src},      32'd0);
    chk("rst_target",  Target_Out,           32'd0);
    chk("rst_timeout", {31'd0, Timeout},     32'd0);
    Reset_n = 1'b1;
    next_cycle();

    // BEQ, no hazard, taken, target 0x40
    Branch_Valid = 1'b1; Branch_Op = OP_BEQ; Branch_Target = 32'h40;
    exp_q.push_back(32'h40); exp_redirects++;
    #1 chk("beq_n_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    Branch_Valid = 1'b0; Branch_Target = '0; Cmp_Result = 1'b1;
    #1 chk("beq_n1_state", {30'd0, Dbg_State}, {30'd0, ST_RESOLVE});
    chk("beq_n1_stall", {31'd0, Stall}, 32'd1);
    chk("beq_n1_cmp", {29'd0, Cmp_Control}, {29'd0, OP_BEQ});
    chk("beq_n1_pc_src", {31'd0, PC_Src}, 32'd0);
    next_cycle();
    Cmp_Result = 1'b0;
    #1 chk("beq_n2_pc_src", {31'd0, PC_Src}, 32'd1);
    chk("beq_n2_flush", {31'd0, Flush}, 32'd1);
    chk("beq_n2_stall", {31'd0, Stall}, 32'd0);
    chk_redirect_target("beq_n2_target");
    next_cycle();

    // BNE accepted at N+3 of the previous branch; Hazard_A high 3 cycles
    Branch_Valid = 1'b1; Branch_Op = OP_BNE; Branch_Target = 32'h100; Hazard_A = 1'b1;
    #1 chk("bne_n_pc_src", {31'd0, PC_Src}, 32'd0);
    chk("bne_n_flush", {31'd0, Flush}, 32'd0);
    chk("bne_n_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    Branch_Valid = 1'b0;
    #1 chk("bne_n1_state", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
    chk("bne_n1_cmp", {29'd0, Cmp_Control}, {29'd0, OP_BNE});
    chk("bne_n1_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    #1 chk("bne_n2_state", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
    next_cycle();
    Hazard_A = 1'b0;
    #1 chk("bne_n3_state", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
    next_cycle();
    #1 chk("bne_n4_state", {30'd0, Dbg_State}, {30'd0, ST_RESOLVE});
    chk("bne_n4_cmp", {29'd0, Cmp_Control}, {29'd0, OP_BNE});
    chk("bne_n4_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    #1 chk("bne_n5_state", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("bne_n5_stall", {31'd0, Stall}, 32'd0);
    chk("bne_n5_pc_src", {31'd0, PC_Src}, 32'd0);
    chk("bne_n5_target", Target_Out, 32'h100);

    // Hazard_B stuck: 16 WAIT cycles, then Timeout pulse in IDLE
    Branch_Valid = 1'b1; Branch_Op = OP_BGTZ; Branch_Target = 32'h200; Hazard_B = 1'b1;
    #1 chk("to_accept_stall", {31'd0, Stall}, 32'd1);
    next_cycle();
    Branch_Valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1 chk("to_wait_state", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
      chk("to_wait_timeout", {31'd0, Timeout}, 32'd0);
      next_cycle();
    end
    #1 chk("to_pulse", {31'd0, Timeout}, 32'd1);
    chk("to_idle", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("to_stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Hazard_B = 1'b0;
    #1 chk("to_pulse_end", {31'd0, Timeout}, 32'd0);
    chk("to_pulse_count", timeout_pulses, 32'd1);

    // Kill in RESOLVE with a taken result
    Branch_Valid = 1'b1; Branch_Op = OP_BLEZ; Branch_Target = 32'h300;
    next_cycle();
    Branch_Valid = 1'b0; Kill = 1'b1; Cmp_Result = 1'b1;
    #1 chk("kr_state", {30'd0, Dbg_State}, {30'd0, ST_RESOLVE});
    chk("kr_flush", {31'd0, Flush}, 32'd0);
    next_cycle();
    Kill = 1'b0; Cmp_Result = 1'b0;
    #1 chk("kr_idle", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("kr_pc_src", {31'd0, PC_Src}, 32'd0);
    chk("kr_flush2", {31'd0, Flush}, 32'd0);

    // Invalid ops are ignored
    Branch_Valid = 1'b1; Branch_Op = 3'b110;
    #1 chk("inv110_stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Branch_Op = 3'b111;
    #1 chk("inv110_state", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("inv111_stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Branch_Valid = 1'b0;
    #1 chk("inv111_state", {30'd0, Dbg_State}, {30'd0, ST_IDLE});

    // Kill during REDIRECT masks PC_Src/Flush
    tgt = 32'($urandom_range(1, 32'h0FFF)) << 2;
    Branch_Valid = 1'b1; Branch_Op = OP_BLTZ; Branch_Target = tgt;
    next_cycle();
    Branch_Valid = 1'b0; Cmp_Result = 1'b1;
    next_cycle();
    Cmp_Result = 1'b0; Kill = 1'b1;
    #1 chk("kd_state", {30'd0, Dbg_State}, {30'd0, ST_REDIRECT});
    chk("kd_pc_src", {31'd0, PC_Src}, 32'd0);
    chk("kd_flush", {31'd0, Flush}, 32'd0);
    chk("kd_target", Target_Out, tgt);
    next_cycle();
    Kill = 1'b0;
    #1 chk("kd_idle", {30'd0, Dbg_State}, {30'd0, ST_IDLE});

    // Branch_Valid with Kill in IDLE is not accepted
    Branch_Valid = 1'b1; Branch_Op = OP_BEQ; Kill = 1'b1;
    #1 chk("ki_stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    Branch_Valid = 1'b0; Kill = 1'b0;
    #1 chk("ki_state", {30'd0, Dbg_State}, {30'd0, ST_IDLE});

    // Kill during WAIT
    Branch_Valid = 1'b1; Branch_Op = OP_BGEZ; Hazard_A = 1'b1;
    next_cycle();
    Branch_Valid = 1'b0; Kill = 1'b1;
    #1 chk("kw_state", {30'd0, Dbg_State}, {30'd0, ST_WAIT});
    next_cycle();
    Kill = 1'b0; Hazard_A = 1'b0;
    #1 chk("kw_idle", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("kw_stall", {31'd0, Stall}, 32'd0);

    // Reset in RESOLVE with a taken result: no redirect afterwards
    Branch_Valid = 1'b1; Branch_Op = OP_BEQ; Branch_Target = 32'h700;
    next_cycle();
    Branch_Valid = 1'b0; Cmp_Result = 1'b1; Reset_n = 1'b0;
    #1 chk("rm_state", {30'd0, Dbg_State}, {30'd0, ST_RESOLVE});
    next_cycle();
    Reset_n = 1'b1; Cmp_Result = 1'b0;
    #1 chk("rm_idle", {30'd0, Dbg_State}, {30'd0, ST_IDLE});
    chk("rm_pc_src", {31'd0, PC_Src}, 32'd0);
    chk("rm_flush", {31'd0, Flush}, 32'd0);
    chk("rm_target", Target_Out, 32'd0);
    chk("rm_cmp", {29'd0, Cmp_Control}, 32'd0);

    // Taken branch with one hazard cycle, random target
    tgt = 32'($urandom_range(1, 32'hFFFF)) << 2;
    run_branch(OP_BGEZ, tgt, 1, 1'b1);

`ifdef BRANCH_STATS_EN
    Reset_n = 1'b0;
    next_cycle();
    Reset_n = 1'b1;
    #1 chk("st_rst_branch", Branch_Count, 32'd0);
    next_cycle();
    run_branch(OP_BEQ,  32'h1000, 0, 1'b1);
    run_branch(OP_BNE,  32'h2000, 2, 1'b0);
    run_branch(OP_BGEZ, 32'h3000, 0, 1'b1);
    run_branch(OP_BLEZ, 32'h4000, 0, 1'b0);
    #1 chk("st_branch_count", Branch_Count, 32'd4);
    chk("st_taken_count", Taken_Count, 32'd2);
    chk("st_stall_cycles", Stall_Cycles, 32'd2);
`endif

    next_cycle();
    chk("redirect_pulses", redirect_pulses, exp_redirects);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
